// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types for the snooping coherence bus arbiter.
//   NUM_CPUS / XLEN     : system defaults for requester count and address width
//   MAX_INFLIGHT_DEF    : default outstanding-transaction table depth
//   bus_tx_t, bus_msg_t : bus transaction kind and broadcast message
//   inflight_entry_t    : one slot of the outstanding-transaction table
package snoop_bus_arbiter_pkg;

  localparam int NUM_CPUS         = 4;
  localparam int XLEN             = 6;
  localparam int MAX_INFLIGHT_DEF = 2;
  localparam int SRC_W            = $clog2(NUM_CPUS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GETS = 2'd1,
    GETM = 2'd2,
    PUTM = 2'd3
  } bus_tx_t;

  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] source;
    logic [XLEN-1:0]  addr;
    bus_tx_t          bus_tx;
  } bus_msg_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
  } inflight_entry_t;

endpackage

// File: rtl/snoop_bus_arbiter_rr.sv
// Generic N-way round-robin picker.
//   elig_i : eligibility mask
//   ptr_i  : highest-priority index this cycle
//   gnt_o  : one-hot grant of the first eligible index at or after ptr_i,
//            wrapping N-1 -> 0; all zero when nothing is eligible
module snoop_bus_arbiter_rr #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     elig_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr_i) + k) % N);
      if (!found && elig_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter / serializer for the snooping coherence bus.
// Grants at most one request per cycle, broadcasts the winner as a registered
// bus message one cycle later, and tracks up to MAX_INFLIGHT outstanding
// transactions so that a second request to a live address waits until the
// memory/xbar completion for that address arrives.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_valid     : per-requester request valid
//   req_msg       : per-requester message (valid/source fields ignored)
//   req_ready     : one-hot grant, combinational, same cycle as accept
//   bus_out       : registered broadcast message
//   cpl_valid/addr: transaction completion from memory/xbar
//   inflight_cnt  : occupied table entries (registered)
//   full          : inflight_cnt == MAX_INFLIGHT
//   cpl_err       : sticky, a completion matched no live entry
//
// Optional build macro: SNOOP_BUS_PUTM_PRIO_EN -- eligible PUTM requests win
// over GETS/GETM, round-robin among the PUTMs; otherwise pure round-robin.
// ADDR_W is expected to be <= XLEN.
module snoop_bus_arbiter
  import snoop_bus_arbiter_pkg::*;
#(
  parameter  int NUM_REQ      = NUM_CPUS,
  parameter  int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter  int ADDR_W       = XLEN,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1,
  localparam int PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  bus_msg_t [NUM_REQ-1:0]   req_msg,
  output logic [NUM_REQ-1:0]       req_ready,
  output bus_msg_t                 bus_out,
  input  logic                     cpl_valid,
  input  logic [ADDR_W-1:0]        cpl_addr,
  output logic [CNT_W-1:0]         inflight_cnt,
  output logic                     full,
  output logic                     cpl_err
);

  inflight_entry_t [MAX_INFLIGHT-1:0] tbl_q, tbl_d;
  logic [PTR_W-1:0]                   ptr_q, ptr_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               err_q, err_d;
  bus_msg_t                           bus_q, bus_d;

  logic [MAX_INFLIGHT-1:0] cpl_hit;
  logic [MAX_INFLIGHT-1:0] live;
  logic                    has_free;
  logic [NUM_REQ-1:0]      addr_blk;
  logic [NUM_REQ-1:0]      elig;
  logic [NUM_REQ-1:0]      gnt;
  logic                    accept;
  logic [PTR_W-1:0]        win_idx;
  logic                    alloc_done;
  logic                    unused_fields;

  // Completion bypass: an entry hit by this cycle's completion is already
  // treated as free, both for address blocking and for capacity.
  always_comb begin
    cpl_hit = '0;
    live    = '0;
    for (int j = 0; j < MAX_INFLIGHT; j++) begin
      cpl_hit[j] = cpl_valid && tbl_q[j].valid &&
                   (tbl_q[j].addr[ADDR_W-1:0] == cpl_addr);
      live[j]    = tbl_q[j].valid && !cpl_hit[j];
    end
  end

  assign has_free = ~&live;

  always_comb begin
    addr_blk = '0;
    elig     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < MAX_INFLIGHT; j++) begin
        if (live[j] && (tbl_q[j].addr[ADDR_W-1:0] == req_msg[i].addr[ADDR_W-1:0]))
          addr_blk[i] = 1'b1;
      end
      elig[i] = req_valid[i] && (req_msg[i].bus_tx != IDLE) &&
                !addr_blk[i] && has_free;
    end
  end

`ifdef SNOOP_BUS_PUTM_PRIO_EN
  logic [NUM_REQ-1:0] putm_elig;
  logic [NUM_REQ-1:0] putm_gnt;
  logic [NUM_REQ-1:0] all_gnt;

  always_comb begin
    putm_elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      putm_elig[i] = elig[i] && (req_msg[i].bus_tx == PUTM);
  end

  snoop_bus_arbiter_rr #(.N(NUM_REQ)) u_rr_putm (
    .elig_i (putm_elig),
    .ptr_i  (ptr_q),
    .gnt_o  (putm_gnt)
  );

  snoop_bus_arbiter_rr #(.N(NUM_REQ)) u_rr_all (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (all_gnt)
  );

  // Any eligible PUTM pre-empts the plain round-robin choice.
  assign gnt = (|putm_gnt) ? putm_gnt : all_gnt;
`else
  snoop_bus_arbiter_rr #(.N(NUM_REQ)) u_rr_all (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt)
  );
`endif

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);

  // The valid/source fields of incoming messages carry no meaning here.
  always_comb begin
    unused_fields = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      unused_fields = unused_fields ^ req_msg[i].valid ^ (^req_msg[i].source);
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) win_idx = PTR_W'(i);
  end

  always_comb begin
    tbl_d      = tbl_q;
    alloc_done = 1'b0;
    for (int j = 0; j < MAX_INFLIGHT; j++)
      if (cpl_hit[j]) tbl_d[j].valid = 1'b0;
    // Lowest free slot (after bypass) takes the newly accepted address.
    if (accept) begin
      for (int j = 0; j < MAX_INFLIGHT; j++) begin
        if (!alloc_done && !live[j]) begin
          tbl_d[j].valid = 1'b1;
          tbl_d[j].addr  = req_msg[win_idx].addr;
          alloc_done     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept)
      ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
  end

  assign cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(|cpl_hit);
  assign err_d = err_q | (cpl_valid & ~|cpl_hit);

  // Without an accept the broadcast fields hold; only valid drops.
  always_comb begin
    bus_d       = bus_q;
    bus_d.valid = 1'b0;
    if (accept) begin
      bus_d.valid  = 1'b1;
      bus_d.source = SRC_W'(win_idx);
      bus_d.addr   = req_msg[win_idx].addr;
      bus_d.bus_tx = req_msg[win_idx].bus_tx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      bus_q <= '{valid: 1'b0, source: '0, addr: '0, bus_tx: IDLE};
    end else begin
      tbl_q <= tbl_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      bus_q <= bus_d;
    end
  end

  assign bus_out      = bus_q;
  assign inflight_cnt = cnt_q;
  assign full         = (cnt_q == CNT_W'(MAX_INFLIGHT));
  assign cpl_err      = err_q;

endmodule
